// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: shared widths, FSM state type and flattened-bus slice helper
package mem_arb_pkg;
    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_e;

    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: single-outstanding memory handshake between arbiter and memory
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  valid;
    logic                  wr_rd;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  ready;

    modport master (output valid, wr_rd, addr, wdata, input rdata, ready);
    modport slave  (input valid, wr_rd, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// mem_rr_pick: first set request at or after ptr, wrapping, as one-hot and index
module mem_rr_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o
);
    logic [IW-1:0] j;

    // scan from the far end back toward ptr so the nearest hit wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        j       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr_i) + k) % N);
            if (req_i[j]) begin
                grant_o    = '0;
                grant_o[j] = 1'b1;
                idx_o      = j;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port with timeout and txn counter
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_AGENTS = 4,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 64
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NUM_AGENTS-1:0]            req_valid_i,
    input  logic [NUM_AGENTS-1:0]            req_wr_rd_i,
    input  logic [NUM_AGENTS*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_AGENTS*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_AGENTS-1:0]            req_ack_o,
    output logic [DATA_WIDTH-1:0]            rdata_o,
    output logic                             err_o,
    output logic [NUM_AGENTS-1:0]            grant_o,
    output logic [31:0]                      txn_count_o,
    mem_arbiter_if.master                    mem
);
    localparam int IW = $clog2(NUM_AGENTS);

    arb_state_e            state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d, idx_q, idx_d, pick_idx;
    logic [NUM_AGENTS-1:0] pick_grant, grant_q, grant_d, ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  err_q, err_d, valid_q, valid_d, wr_q, wr_d;
    logic [31:0]           cnt_q, cnt_d, tmo_q, tmo_d;

    mem_rr_pick #(.N(NUM_AGENTS)) u_pick (
        .req_i  (req_valid_i),
        .ptr_i  (ptr_q),
        .grant_o(pick_grant),
        .idx_o  (pick_idx)
    );

    assign req_ack_o   = ack_q;
    assign rdata_o     = rdata_q;
    assign err_o       = err_q;
    assign grant_o     = grant_q;
    assign txn_count_o = cnt_q;
    assign mem.valid   = valid_q;
    assign mem.wr_rd   = wr_q;
    assign mem.addr    = addr_q;
    assign mem.wdata   = wdata_q;

    // state and every output register; reset drops any in-flight request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            grant_q <= '0;
            ack_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // capture in IDLE, wait for ready or timeout in BUSY, one-cycle ack in DONE
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        grant_d = grant_q;
        ack_d   = '0;
        rdata_d = rdata_q;
        err_d   = err_q;
        valid_d = valid_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: if (|req_valid_i) begin
                state_d = BUSY;
                idx_d   = pick_idx;
                grant_d = pick_grant;
                valid_d = 1'b1;
                wr_d    = req_wr_rd_i[pick_idx];
                addr_d  = req_addr_i[slice_lsb(int'(pick_idx), ADDR_WIDTH) +: ADDR_WIDTH];
                wdata_d = req_wdata_i[slice_lsb(int'(pick_idx), DATA_WIDTH) +: DATA_WIDTH];
                tmo_d   = '0;
            end
            BUSY: if (mem.ready) begin
                state_d = DONE;
                valid_d = 1'b0;
                rdata_d = wr_q ? '0 : mem.rdata;
                err_d   = 1'b0;
                ack_d   = grant_q;
                cnt_d   = &cnt_q ? cnt_q : cnt_q + 32'd1;
            end else if (TIMEOUT > 0 && tmo_q + 32'd1 == 32'(TIMEOUT)) begin
                state_d = DONE;
                valid_d = 1'b0;
                rdata_d = '0;
                err_d   = 1'b1;
                ack_d   = grant_q;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                rdata_d = '0;
                err_d   = 1'b0;
                ptr_d   = (idx_q == IW'(NUM_AGENTS - 1)) ? '0 : idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks against a transaction-level model
module tb_mem_arbiter;
    localparam int N   = 4;
    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_wr = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    ack, grant;
    logic [DW-1:0]   rdata;
    logic            err;
    logic [31:0]     txn;

    mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    mem_arbiter #(.NUM_AGENTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_valid_i(req_valid),
        .req_wr_rd_i(req_wr),
        .req_addr_i (req_addr),
        .req_wdata_i(req_wdata),
        .req_ack_o  (ack),
        .rdata_o    (rdata),
        .err_o      (err),
        .grant_o    (grant),
        .txn_count_o(txn),
        .mem        (mem_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // transaction-level model: who owns the port, how long it waited, whether it is acking
    int            m_owner = -1;
    int            m_wait = 0;
    int            m_ptr = 0;
    bit            m_done = 1'b0;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_err = 1'b0;
    logic [31:0]   m_cnt = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_wait  = 0;
            m_ptr   = 0;
            m_done  = 1'b0;
            m_cnt   = '0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++)
                if (req_valid[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    break;
                end
            if (m_owner >= 0) begin
                m_wr    = req_wr[m_owner];
                m_addr  = req_addr[m_owner*AW +: AW];
                m_wdata = req_wdata[m_owner*DW +: DW];
                m_wait  = 0;
            end
        end else if (!m_done) begin
            if (mem_if.ready) begin
                m_done  = 1'b1;
                m_err   = 1'b0;
                m_rdata = m_wr ? '0 : mem_if.rdata;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
            end else begin
                m_wait++;
                if (TMO > 0 && m_wait == TMO) begin
                    m_done  = 1'b1;
                    m_err   = 1'b1;
                    m_rdata = '0;
                end
            end
        end else begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_done  = 1'b0;
        end
    end

    logic         e_valid;
    logic [N-1:0] e_grant, e_ack;

    always @(negedge clk) begin
        e_valid = m_owner >= 0 && !m_done;
        e_grant = '0;
        e_ack   = '0;
        if (m_owner >= 0) e_grant[m_owner] = 1'b1;
        if (m_done) e_ack = e_grant;
        check("mem_valid", mem_if.valid, e_valid);
        check("grant", grant, e_grant);
        check("ack", ack, e_ack);
        check("txn_count", txn, m_cnt);
        if (e_valid) begin
            check("mem_wr_rd", mem_if.wr_rd, m_wr);
            check("mem_addr", mem_if.addr, m_addr);
            check("mem_wdata", mem_if.wdata, m_wdata);
        end
        if (e_ack != '0) begin
            check("rdata", rdata, m_rdata);
            check("err", err, m_err);
        end
    end

    int            vc;
    logic [N-1:0]  ga;
    logic [DW-1:0] gr;
    logic          ge;
    logic [AW-1:0] last_addr;
    logic          last_wr;

    task automatic do_txn(input int a, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input logic [DW-1:0] mrd, input int wait_n, output int vcyc,
                          output logic [N-1:0] a_ack, output logic [DW-1:0] a_rd, output logic a_err);
        req_valid[a] = 1'b1;
        req_wr[a] = wr;
        req_addr[a*AW +: AW] = addr;
        req_wdata[a*DW +: DW] = wd;
        mem_if.rdata = mrd;
        mem_if.ready = 1'b0;
        vcyc = 0;
        a_ack = '0;
        a_rd = '0;
        a_err = 1'b0;
        for (int t = 0; t < 100 && a_ack == '0; t++) begin
            @(negedge clk);
            if (mem_if.valid) begin
                vcyc++;
                last_addr = mem_if.addr;
                last_wr = mem_if.wr_rd;
                mem_if.ready = vcyc > wait_n;
            end
            if (ack != '0) begin
                a_ack = ack;
                a_rd = rdata;
                a_err = err;
                req_valid[a] = 1'b0;
                mem_if.ready = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst = 1'b1;
        req_valid = '0;
        mem_if.ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_payload(input int i);
        req_wr[i] = 1'($urandom);
        req_addr[i*AW +: AW] = AW'($urandom);
        req_wdata[i*DW +: DW] = DW'($urandom);
    endtask

    logic [N-1:0] acks[$];
    int           stamps[$];
    int           cyc;
    int           rnd_acks = 0;
    int           rnd_tmo = 0;
    int           pcts[4] = '{60, 0, 100, 20};
    int           pct;
    logic [N-1:0] exp_fair[6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    logic [N-1:0] exp_wrap[3] = '{4'b0100, 4'b0001, 4'b0100};

    initial begin
        mem_if.ready = 1'b0;
        mem_if.rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_valid", mem_if.valid, 0);
        check("rst_grant", grant, 0);
        check("rst_ack", ack, 0);
        check("rst_txn", txn, 0);
        rst = 1'b0;

        do_txn(1, 1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, 2, vc, ga, gr, ge);
        check("wr_valid_cycles", vc, 3);
        check("wr_addr", last_addr, 16'h0010);
        check("wr_wr_rd", last_wr, 1);
        check("wr_ack", ga, 4'b0010);
        check("wr_err", ge, 0);
        check("wr_txn", txn, 1);

        do_txn(1, 1'b0, 16'h0010, 32'h0, 32'hDEADBEEF, 0, vc, ga, gr, ge);
        check("rd_valid_cycles", vc, 1);
        check("rd_ack", ga, 4'b0010);
        check("rd_data", gr, 32'hDEADBEEF);
        check("rd_txn", txn, 2);

        do_txn(2, 1'b0, 16'h0ABC, 32'h0, 32'h12345678, 1000, vc, ga, gr, ge);
        check("tmo_valid_cycles", vc, TMO);
        check("tmo_ack", ga, 4'b0100);
        check("tmo_err", ge, 1);
        check("tmo_rdata", gr, 0);
        check("tmo_txn", txn, 2);

        req_valid[0] = 1'b1;
        req_wr[0] = 1'b1;
        for (int t = 0; t < 20 && !mem_if.valid; t++) @(negedge clk);
        check("mid_busy_valid", mem_if.valid, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", mem_if.valid, 0);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_txn", txn, 0);
        check("mid_rst_ack", ack, 0);
        @(negedge clk);
        check("mid_rst_no_ack", ack, 0);
        rst = 1'b0;
        req_valid = 4'b1001;
        mem_if.ready = 1'b1;
        ga = '0;
        for (int t = 0; t < 20 && ga == '0; t++) begin
            @(negedge clk);
            ga = ack;
        end
        check("post_rst_first", ga, 4'b0001);
        req_valid = '0;
        mem_if.ready = 1'b0;

        do_reset();
        req_valid = '1;
        mem_if.ready = 1'b1;
        cyc = 0;
        for (int t = 0; t < 100 && acks.size() < 6; t++) begin
            @(negedge clk);
            cyc++;
            if (ack != '0) begin
                acks.push_back(ack);
                stamps.push_back(cyc);
            end
        end
        req_valid = 4'b0101;
        check("fair_count", acks.size(), 6);
        for (int i = 0; i < 6 && i < acks.size(); i++) begin
            check($sformatf("fair_order%0d", i), acks[i], exp_fair[i]);
            if (i > 0) check($sformatf("fair_gap%0d", i), stamps[i] - stamps[i-1], 3);
        end
        acks.delete();
        for (int t = 0; t < 100 && acks.size() < 3; t++) begin
            @(negedge clk);
            if (ack != '0) acks.push_back(ack);
        end
        check("wrap_count", acks.size(), 3);
        for (int i = 0; i < 3 && i < acks.size(); i++)
            check($sformatf("wrap_order%0d", i), acks[i], exp_wrap[i]);
        req_valid = '0;
        mem_if.ready = 1'b0;
        repeat (3) @(negedge clk);

        pct = pcts[0];
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) pct = pcts[(c / 250) % 4];
            mem_if.ready = int'($urandom_range(99)) < pct;
            mem_if.rdata = DW'($urandom);
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    req_valid[i] = 1'($urandom);
                    set_payload(i);
                end else if (!req_valid[i] && $urandom_range(3) == 0) begin
                    req_valid[i] = 1'b1;
                    set_payload(i);
                end
            end
            if ($urandom_range(29) == 0) req_valid[$urandom_range(N-1)] = 1'b0;
            if ($urandom_range(9) == 0) set_payload(int'($urandom_range(N-1)));
            @(negedge clk);
            if (ack != '0) begin
                rnd_acks++;
                if (err) rnd_tmo++;
            end
        end
        check("rnd_progress", rnd_acks > 100, 1);
        check("rnd_timeouts_seen", rnd_tmo > 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one memory slave port among NUM_AGENTS requesters.
- The memory port carries valid/wr_rd/addr/wdata/rdata/ready.
- Captures one request at a time, drives the memory handshake until ready, and returns read data and completion to the granted requester.
- Adds a per-transaction timeout and a completed-transaction counter; sits directly in front of the memory in the test top.

Parameters:
NUM_AGENTS, 4, number of requesters (2..8)
ADDR_WIDTH, 16, address width
DATA_WIDTH, 32, data width
TIMEOUT, 64, BUSY cycles without mem_ready_i before abort; 0 disables timeout

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
req_valid_i  input  NUM_AGENTS  per-requester request; held until that requester's ack
req_wr_rd_i  input  NUM_AGENTS  per-requester 1=write, 0=read
req_addr_i  input  NUM_AGENTS*ADDR_WIDTH  flattened addresses; requester i at slice i
req_wdata_i  input  NUM_AGENTS*DATA_WIDTH  flattened write data
req_ack_o  output  NUM_AGENTS  one-hot completion pulse, one cycle
rdata_o  output  DATA_WIDTH  read data, valid while req_ack_o != 0
err_o  output  1  timeout flag, valid while req_ack_o != 0
grant_o  output  NUM_AGENTS  one-hot current owner, nonzero in BUSY and DONE
mem_valid_o  output  1  memory request valid
mem_wr_rd_o  output  1  memory write/read select
mem_addr_o  output  ADDR_WIDTH  memory address
mem_wdata_o  output  DATA_WIDTH  memory write data
mem_rdata_i  input  DATA_WIDTH  memory read data, sampled with mem_ready_i
mem_ready_i  input  1  memory completion
txn_count_o  output  32  completed (non-error) transactions, saturating

Behaviour:
- Reset (asynchronous, rst_i=1):
  - All outputs 0, state IDLE, rr pointer 0, timeout counter 0, txn_count_o 0.
  - mem_valid_o falls immediately even mid-transaction; the in-flight request is dropped with no ack.
- FSM: IDLE -> BUSY -> DONE -> IDLE. All outputs are registered.
- IDLE:
  - If any req_valid_i is set at the clock edge, pick the first set bit scanning ptr, ptr+1, ..., wrapping mod NUM_AGENTS.
  - Capture that requester's wr_rd/addr/wdata into mem_*_o, set grant_o, set mem_valid_o=1, go to BUSY.
  - Latency: request sampled at edge k gives mem_valid_o high after edge k.
- BUSY:
  - mem_valid_o and all mem_*_o are held stable.
  - Requester input changes are ignored; the captured copy is used.
  - If mem_ready_i=1 at an edge: mem_valid_o=0, rdata_o = mem_rdata_i for reads (0 for writes), err_o=0, req_ack_o=grant_o, txn_count_o++ (saturating at 0xFFFFFFFF), go to DONE.
  - Timeout: when TIMEOUT>0 and the counter reaches TIMEOUT with no ready, mem_valid_o=0, rdata_o=0, err_o=1, req_ack_o=grant_o, no count increment, go to DONE.
  - The counter clears on entering BUSY.
- DONE (one cycle):
  - req_ack_o, rdata_o and err_o are valid.
  - No arbitration occurs in this cycle.
  - ptr = (granted index + 1) mod NUM_AGENTS.
  - On exit, req_ack_o, grant_o, rdata_o and err_o clear to 0.
  - The requester must deassert or replace req_valid_i by the edge ending DONE.
- Throughput: minimum 3 cycles per transaction when mem_ready_i is high on the first BUSY edge.
- A mem_ready_i seen in IDLE or DONE is ignored.
- A requester that deasserts req_valid_i while in BUSY still receives its ack.
- Simultaneous requests are resolved only by the rr pointer. No starvation: every valid requester is served within NUM_AGENTS grants.

Decomposition:
- Package mem_arb_pkg:
  - ADDR_WIDTH/DATA_WIDTH defaults (16/32).
  - Enum arb_state_e {IDLE, BUSY, DONE}.
  - Function for the flattened-slice index.
- Sub-module mem_rr_pick: combinational, inputs req vector and ptr, outputs one-hot grant and binary index.

Test Plan:
- Single write: N=4, req1 write addr 0x0010 data 0xDEADBEEF, mem_ready_i after 2 BUSY cycles -> mem_valid_o high 3 cycles with addr 0x0010 and wr_rd 1; req_ack_o=0010 for one cycle; err_o=0; txn_count_o=1.
- Read back: req1 read 0x0010, memory returns 0xDEADBEEF -> rdata_o=0xDEADBEEF while req_ack_o[1]=1; txn_count_o=2.
- Fairness: all four requesters held valid from reset, ready in 1 cycle -> grant order 0,1,2,3,0,1; each ack spaced 3 cycles apart.
- Wrap and skip: after a grant to 2, only requesters 0 and 2 valid -> ptr=3, next grant to 0, then 2.
- Timeout: TIMEOUT=8, mem_ready_i held 0 -> mem_valid_o drops after 8 BUSY cycles; ack with err_o=1, rdata_o=0; txn_count_o unchanged.
- Reset mid-BUSY: assert rst_i between edges during BUSY -> mem_valid_o, grant_o and txn_count_o go 0 immediately with no ack; after release, simultaneous requests from 0 and 3 grant 0 first.
